// File: rtl/mm2axi4_burst.sv
// mm2axi4_burst: SoC memory bus (a/d/we/rd/spo/ready) to AXI4 master bridge with INCR bursts.
// One transaction at a time; ready pulses per beat, last on the final beat, irq on bad responses.
module mm2axi4_burst #(
    parameter int AXI4_IDLEN   = 4,
    parameter int AXI4_ADDRLEN = 27,
    parameter int AXI4_DATALEN = 32,
    parameter int MAX_BURST    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               a,
    input  logic [AXI4_DATALEN-1:0]   d,
    input  logic                      we,
    input  logic                      rd,
    input  logic                      burst_en,
    input  logic [7:0]                burst_length,
    output logic [AXI4_DATALEN-1:0]   spo,
    output logic                      ready,
    output logic                      last,
    output logic                      irq,
    output logic [AXI4_IDLEN-1:0]     m_axi_awid,
    output logic [AXI4_ADDRLEN-1:0]   m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AXI4_IDLEN-1:0]     m_axi_wid,
    output logic [AXI4_DATALEN-1:0]   m_axi_wdata,
    output logic [AXI4_DATALEN/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [AXI4_IDLEN-1:0]     m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [AXI4_IDLEN-1:0]     m_axi_arid,
    output logic [AXI4_ADDRLEN-1:0]   m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI4_IDLEN-1:0]     m_axi_rid,
    input  logic [AXI4_DATALEN-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int LSB = $clog2(AXI4_DATALEN / 8);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI4_ADDRLEN-1:0]   addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                beat_q, beat_d;
    logic [AXI4_DATALEN-1:0]   spo_q, spo_d;
    logic                      ready_q, ready_d;
    logic                      last_q, last_d;
    logic                      irq_q, irq_d;
    logic                      wgap_q, wgap_d;
    logic                      final_beat;
    logic                      unused_ok;

    function automatic logic [7:0] calc_axlen(input logic en, input logic [7:0] bl);
        int n;
        n = en ? int'(bl) : 1;
        if (n < 1) n = 1;
        if (n > MAX_BURST) n = MAX_BURST;
        return 8'(n - 1);
    endfunction

    assign final_beat = (beat_q == len_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            spo_q   <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            irq_q   <= 1'b0;
            wgap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            spo_q   <= spo_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            irq_q   <= irq_d;
            wgap_q  <= wgap_d;
        end
    end

    // Address and length only matter once a transaction is latched, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        len_q  <= len_d;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        spo_d   = spo_q;
        ready_d = 1'b0;
        last_d  = 1'b0;
        irq_d   = 1'b0;
        wgap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (rd || we) begin
                    addr_d  = {a[AXI4_ADDRLEN-1:LSB], {LSB{1'b0}}};
                    len_d   = calc_axlen(burst_en, burst_length);
                    state_d = rd ? RD_ADDR : WR_ADDR;
                end
            end
            RD_ADDR: if (m_axi_arready) state_d = RD_DATA;
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    spo_d   = m_axi_rdata;
                    ready_d = 1'b1;
                    beat_d  = beat_q + 8'd1;
                    irq_d   = (m_axi_rresp != 2'b00) || (m_axi_rlast != final_beat);
                    // An early rlast ends the burst here rather than waiting for beats that never come.
                    if (final_beat || m_axi_rlast) begin
                        last_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WR_ADDR: if (m_axi_awready) state_d = WR_DATA;
            WR_DATA: begin
                if (m_axi_wvalid && m_axi_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (final_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        ready_d = 1'b1;
                        wgap_d  = 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    ready_d = 1'b1;
                    last_d  = 1'b1;
                    irq_d   = (m_axi_bresp != 2'b00);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign spo   = spo_q;
    assign ready = ready_q;
    assign last  = last_q;
    assign irq   = irq_q;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'(LSB);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awvalid = (state_q == WR_ADDR);

    // The wgap cycle lets the requester present the next d after each ready pulse.
    assign m_axi_wid    = '0;
    assign m_axi_wdata  = d;
    assign m_axi_wstrb  = '1;
    assign m_axi_wlast  = final_beat;
    assign m_axi_wvalid = (state_q == WR_DATA) && !wgap_q;

    assign m_axi_bready = (state_q == WR_RESP);

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'(LSB);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = (state_q == RD_ADDR);

    assign m_axi_rready = (state_q == RD_DATA);

    assign unused_ok = ^{m_axi_bid, m_axi_rid, a};

endmodule

// File: tb/tb_mm2axi4_burst.sv
// Directed bench for mm2axi4_burst: the bench plays requester and AXI4 slave, all
// stimulus applied and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mm2axi4_burst;
    localparam int IDW = 4;
    localparam int AW  = 27;
    localparam int DW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, we, rd, burst_en, ready, last, irq;
    logic [31:0]     a;
    logic [DW-1:0]   d, spo;
    logic [7:0]      burst_length;
    logic [IDW-1:0]  m_axi_awid, m_axi_wid, m_axi_bid, m_axi_arid, m_axi_rid;
    logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [7:0]      m_axi_awlen, m_axi_arlen;
    logic [2:0]      m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]      m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic            m_axi_awlock, m_axi_arlock;
    logic [3:0]      m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic            m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

    mm2axi4_burst #(.AXI4_IDLEN(IDW), .AXI4_ADDRLEN(AW), .AXI4_DATALEN(DW), .MAX_BURST(32)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .rd(rd), .burst_en(burst_en),
        .burst_length(burst_length), .spo(spo), .ready(ready), .last(last), .irq(irq),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Monitor: log every ready pulse with its data/last, count irq pulses and awvalid cycles.
    int          rdy_cnt = 0;
    int          irq_cnt = 0;
    int          aw_cyc  = 0;
    logic [31:0] spo_log [1024];
    logic        last_log[1024];
    always @(negedge clk) begin
        if (ready) begin
            spo_log[rdy_cnt[9:0]]  <= spo;
            last_log[rdy_cnt[9:0]] <= last;
            rdy_cnt <= rdy_cnt + 1;
        end
        if (irq) irq_cnt <= irq_cnt + 1;
        if (m_axi_awvalid) aw_cyc <= aw_cyc + 1;
    end

    // Values captured by the stimulus tasks for the test tasks to judge.
    logic [AW-1:0] cap_addr;
    logic [7:0]    cap_len;
    logic [2:0]    cap_size;
    logic [1:0]    cap_burst;
    logic [31:0]   wd_log[64];
    logic          wl_log[64];
    int            ar_drop, pre_b_rdy, b_wait_rdy;
    logic          fin_ok;

    task automatic run_read(input logic [31:0] addr, input logic ben, input logic [7:0] blen,
                            input int ar_dly, input int gap, input int err_beat,
                            input int early_beat, input logic also_we, input logic [31:0] rbase);
        int t;
        int beats;
        fin_ok  = 1'b0;
        ar_drop = 0;
        @(negedge clk);
        a = addr; burst_en = ben; burst_length = blen; rd = 1'b1; we = also_we;
        t = 0;
        do begin @(negedge clk); t++; end while (!m_axi_arvalid && t < 50);
        if (!m_axi_arvalid) begin
            n_assert++; n_fail++;
            $display("FAIL rd_arvalid_timeout: arvalid=%0b required 1", m_axi_arvalid);
            rd = 1'b0; we = 1'b0;
            return;
        end
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            if (!m_axi_arvalid) ar_drop++;
        end
        cap_addr = m_axi_araddr; cap_len = m_axi_arlen;
        cap_size = m_axi_arsize; cap_burst = m_axi_arburst;
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        beats = int'(cap_len) + 1;
        for (int i = 0; i < beats; i++) begin
            if (gap > 0 && (i % 2) == 1) begin
                m_axi_rvalid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rbase + 32'(i);
            m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (i == early_beat) || (early_beat < 0 && i == beats - 1);
            t = 0;
            while (!m_axi_rready && t < 50) begin @(negedge clk); t++; end
            if (!m_axi_rready) begin
                n_assert++; n_fail++;
                $display("FAIL rd_rready_timeout: beat %0d rready=%0b required 1", i, m_axi_rready);
                break;
            end
            @(negedge clk);
            if (i == beats - 1 || i == early_beat) fin_ok = ready && last;
            if (i == early_beat) break;
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        rd = 1'b0; we = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] blen,
                             input int b_dly, input int stop_after);
        int t, k, beats, wr_rdy;
        fin_ok = 1'b0; pre_b_rdy = 0; b_wait_rdy = 0;
        @(negedge clk);
        a = addr; burst_en = 1'b1; burst_length = blen; d = 32'd1; we = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!m_axi_awvalid && t < 50);
        if (!m_axi_awvalid) begin
            n_assert++; n_fail++;
            $display("FAIL wr_awvalid_timeout: awvalid=%0b required 1", m_axi_awvalid);
            we = 1'b0;
            return;
        end
        @(negedge clk);
        cap_addr = m_axi_awaddr; cap_len = m_axi_awlen;
        cap_size = m_axi_awsize; cap_burst = m_axi_awburst;
        m_axi_awready = 1'b1;
        @(negedge clk);
        m_axi_awready = 1'b0;
        beats = int'(cap_len) + 1;
        k = 0; wr_rdy = 0; t = 0;
        while (k < beats && k != stop_after && t < 300) begin
            if (ready) begin
                wr_rdy++;
                d = 32'(wr_rdy + 1);
            end
            m_axi_wready = ($urandom_range(0, 2) != 0);
            if (m_axi_wvalid && m_axi_wready) begin
                wd_log[k] = m_axi_wdata;
                wl_log[k] = m_axi_wlast;
                k++;
            end
            @(negedge clk);
            t++;
        end
        m_axi_wready = 1'b0;
        if (k == stop_after) return;
        if (k < beats) begin
            n_assert++; n_fail++;
            $display("FAIL wr_data_timeout: beats accepted=%0d required %0d", k, beats);
            we = 1'b0;
            return;
        end
        pre_b_rdy = wr_rdy;
        for (int i = 0; i < b_dly; i++) begin
            if (ready) b_wait_rdy++;
            @(negedge clk);
        end
        t = 0;
        while (!m_axi_bready && t < 50) begin @(negedge clk); t++; end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        fin_ok = ready && last;
        we = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, ready, last, irq} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: av/aw/w/rr/br/rdy/last/irq=%b required 00000000",
                     {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, ready, last, irq});
        end
        n_assert++;
        if (spo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_spo: spo=%h required 00000000", spo);
        end
        n_assert++;
        if ({m_axi_awid, m_axi_wid, m_axi_arid, m_axi_awlock, m_axi_arlock, m_axi_awcache, m_axi_arcache,
             m_axi_awprot, m_axi_arprot, m_axi_awqos, m_axi_arqos} !== 36'd0 ||
            {m_axi_awsize, m_axi_awburst, m_axi_arsize, m_axi_arburst, m_axi_wstrb} !== 14'b010_01_010_01_1111) begin
            n_fail++;
            $display("FAIL reset_consts: size/burst/strb=%b required 01001010011111",
                     {m_axi_awsize, m_axi_awburst, m_axi_arsize, m_axi_arburst, m_axi_wstrb});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int r0, i0;
        r0 = rdy_cnt; i0 = irq_cnt;
        run_read(32'h100, 1'b0, 8'd0, 3, 0, -1, -1, 1'b0, 32'hDEADBEEF);
        n_assert++;
        if (ar_drop !== 0) begin n_fail++; $display("FAIL sr_arvalid_hold: drops=%0d required 0", ar_drop); end
        n_assert++;
        if (cap_addr !== 27'h100 || cap_len !== 8'd0) begin
            n_fail++; $display("FAIL sr_ar: araddr=%h arlen=%0d required 100 / 0", cap_addr, cap_len);
        end
        n_assert++;
        if ({cap_size, cap_burst} !== 5'b010_01) begin
            n_fail++; $display("FAIL sr_size_burst: %b required 01001", {cap_size, cap_burst});
        end
        n_assert++;
        if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL sr_ready_count: %0d required 1", rdy_cnt - r0); end
        n_assert++;
        if (spo_log[r0[9:0]] !== 32'hDEADBEEF || last_log[r0[9:0]] !== 1'b1) begin
            n_fail++; $display("FAIL sr_data: spo=%h last=%b required deadbeef / 1", spo_log[r0[9:0]], last_log[r0[9:0]]);
        end
        n_assert++;
        if (fin_ok !== 1'b1) begin n_fail++; $display("FAIL sr_latency: ready&last after R=%b required 1", fin_ok); end
        n_assert++;
        if (irq_cnt - i0 !== 0) begin n_fail++; $display("FAIL sr_irq: %0d required 0", irq_cnt - i0); end
    endtask

    task automatic test_read_burst();
        int r0, i0, idx;
        r0 = rdy_cnt; i0 = irq_cnt;
        run_read(32'h1000, 1'b1, 8'd8, 0, 2, -1, -1, 1'b0, 32'hA0000000);
        n_assert++;
        if (cap_addr !== 27'h1000 || cap_len !== 8'd7) begin
            n_fail++; $display("FAIL rb_ar: araddr=%h arlen=%0d required 1000 / 7", cap_addr, cap_len);
        end
        n_assert++;
        if (rdy_cnt - r0 !== 8) begin n_fail++; $display("FAIL rb_ready_count: %0d required 8", rdy_cnt - r0); end
        for (int i = 0; i < 8; i++) begin
            idx = r0 + i;
            n_assert++;
            if (spo_log[idx[9:0]] !== 32'hA0000000 + 32'(i) || last_log[idx[9:0]] !== (i == 7)) begin
                n_fail++;
                $display("FAIL rb_beat%0d: spo=%h last=%b required %h / %b", i, spo_log[idx[9:0]],
                         last_log[idx[9:0]], 32'hA0000000 + 32'(i), (i == 7));
            end
        end
        n_assert++;
        if (fin_ok !== 1'b1 || irq_cnt - i0 !== 0) begin
            n_fail++; $display("FAIL rb_end: fin=%b irq=%0d required 1 / 0", fin_ok, irq_cnt - i0);
        end
    endtask

    task automatic test_len_clamp();
        int r0, w0;
        run_read(32'h200, 1'b1, 8'd0, 0, 0, -1, -1, 1'b0, 32'h0);
        n_assert++;
        if (cap_len !== 8'd0) begin n_fail++; $display("FAIL clamp_zero: arlen=%0d required 0", cap_len); end
        r0 = rdy_cnt;
        run_read(32'h300, 1'b1, 8'd200, 0, 0, -1, -1, 1'b0, 32'h0);
        n_assert++;
        if (cap_len !== 8'd31 || rdy_cnt - r0 !== 32) begin
            n_fail++; $display("FAIL clamp_max: arlen=%0d beats=%0d required 31 / 32", cap_len, rdy_cnt - r0);
        end
        run_read(32'h400, 1'b0, 8'd5, 0, 0, -1, -1, 1'b0, 32'h0);
        n_assert++;
        if (cap_len !== 8'd0) begin n_fail++; $display("FAIL single_ignores_len: arlen=%0d required 0", cap_len); end
        r0 = rdy_cnt; w0 = aw_cyc;
        run_read(32'h500, 1'b0, 8'd0, 1, 0, -1, -1, 1'b1, 32'h77);
        n_assert++;
        if (aw_cyc - w0 !== 0 || rdy_cnt - r0 !== 1 || cap_addr !== 27'h500) begin
            n_fail++;
            $display("FAIL rd_priority: aw cycles=%0d readys=%0d araddr=%h required 0 / 1 / 500",
                     aw_cyc - w0, rdy_cnt - r0, cap_addr);
        end
    endtask

    task automatic test_read_errors();
        int r0, i0, idx1, idx2;
        r0 = rdy_cnt; i0 = irq_cnt;
        run_read(32'h800, 1'b1, 8'd4, 1, 0, 1, 2, 1'b0, 32'h55);
        idx1 = r0 + 1; idx2 = r0 + 2;
        n_assert++;
        if (cap_len !== 8'd3) begin n_fail++; $display("FAIL re_arlen: %0d required 3", cap_len); end
        n_assert++;
        if (irq_cnt - i0 !== 2) begin n_fail++; $display("FAIL re_irq_count: %0d required 2", irq_cnt - i0); end
        n_assert++;
        if (rdy_cnt - r0 !== 3) begin n_fail++; $display("FAIL re_ready_count: %0d required 3", rdy_cnt - r0); end
        n_assert++;
        if (spo_log[idx1[9:0]] !== 32'h56 || last_log[idx1[9:0]] !== 1'b0 || last_log[idx2[9:0]] !== 1'b1) begin
            n_fail++;
            $display("FAIL re_beats: spo1=%h last1=%b last2=%b required 56 / 0 / 1",
                     spo_log[idx1[9:0]], last_log[idx1[9:0]], last_log[idx2[9:0]]);
        end
        n_assert++;
        if (fin_ok !== 1'b1) begin n_fail++; $display("FAIL re_finish: %b required 1", fin_ok); end
    endtask

    task automatic test_write_burst();
        int r0, i0;
        r0 = rdy_cnt; i0 = irq_cnt;
        run_write(32'h2003, 8'd4, 3, -1);
        n_assert++;
        if (cap_addr !== 27'h2000 || cap_len !== 8'd3 || {cap_size, cap_burst} !== 5'b010_01) begin
            n_fail++; $display("FAIL wb_aw: awaddr=%h awlen=%0d required 2000 / 3", cap_addr, cap_len);
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (wd_log[i] !== 32'(i + 1) || wl_log[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL wb_beat%0d: wdata=%h wlast=%b required %h / %b", i, wd_log[i], wl_log[i],
                         32'(i + 1), (i == 3));
            end
        end
        n_assert++;
        if (pre_b_rdy !== 3 || b_wait_rdy !== 0) begin
            n_fail++; $display("FAIL wb_ready_before_b: %0d / %0d required 3 / 0", pre_b_rdy, b_wait_rdy);
        end
        n_assert++;
        if (fin_ok !== 1'b1 || rdy_cnt - r0 !== 4 || irq_cnt - i0 !== 0) begin
            n_fail++;
            $display("FAIL wb_finish: fin=%b readys=%0d irq=%0d required 1 / 4 / 0", fin_ok, rdy_cnt - r0, irq_cnt - i0);
        end
    endtask

    task automatic test_reset_mid_write();
        int r0;
        run_write(32'h3000, 8'd4, 3, 2);
        rst_n = 1'b0; we = 1'b0;
        @(negedge clk);
        n_assert++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, ready, last} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset: av/aw/w/rr/br/rdy/last=%b required 0000000",
                     {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready, ready, last});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 4'b0) begin
            n_fail++; $display("FAIL post_reset_idle: %b required 0000",
                               {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        end
        r0 = rdy_cnt;
        run_read(32'h3100, 1'b0, 8'd0, 1, 0, -1, -1, 1'b0, 32'h12345678);
        n_assert++;
        if (cap_addr !== 27'h3100 || rdy_cnt - r0 !== 1 || spo_log[r0[9:0]] !== 32'h12345678 || fin_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_read: araddr=%h readys=%0d spo=%h fin=%b required 3100 / 1 / 12345678 / 1",
                     cap_addr, rdy_cnt - r0, spo_log[r0[9:0]], fin_ok);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a = '0; d = '0; we = 1'b0; rd = 1'b0; burst_en = 1'b0; burst_length = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        test_reset();
        test_single_read();
        test_read_burst();
        test_write_burst();
        test_len_clamp();
        test_read_errors();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
